// File: rtl/sprite_anim_bitmap.sv
// ---------------------------------------------------------------------------
// sprite_anim_bitmap
//
// Animated, rotatable sprite bitmap. A constant ROM holds NUM_FRAMES flight
// frames followed by EXPL_FRAMES explosion frames, each OBJECT_HEIGHT_Y rows
// by OBJECT_WIDTH_X columns of 8-bit colour. A small state machine steps
// through the flight loop on startOfFrame pulses, plays the explosion once
// on request, and then blanks the sprite until restarted.
//
// Ports
//   clk             : single clock, all state changes on the rising edge
//   resetN          : asynchronous active-low reset
//   offsetX/offsetY : pixel offset from the sprite's top-left corner
//   InsideRectangle : current pixel lies within the sprite bracket
//   direction       : 0 up, 1 right, 2 down, 3 left (bitmap rotation)
//   startOfFrame    : one-cycle pulse per video frame (animation tick)
//   explode         : one-cycle pulse requesting the explosion sequence
//   restart         : one-cycle pulse re-arming the sprite to flight
//   drawingRequest  : pixel is to be displayed (RGBout not transparent)
//   RGBout          : registered pixel colour, one cycle after the offsets
//   exploding       : high while the explosion sequence is playing
//   explosionDone   : one-cycle pulse when the explosion sequence ends
// ---------------------------------------------------------------------------
module sprite_anim_bitmap #(
    parameter int          OBJECT_WIDTH_X       = 25,
    parameter int          OBJECT_HEIGHT_Y      = 25,
    parameter int          NUM_FRAMES           = 4,
    parameter int          EXPL_FRAMES          = 3,
    parameter int          FRAME_HOLD           = 8,
    parameter logic [7:0]  TRANSPARENT_ENCODING = 8'hFF
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        InsideRectangle,
    input  logic [1:0]  direction,
    input  logic        startOfFrame,
    input  logic        explode,
    input  logic        restart,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic        exploding,
    output logic        explosionDone
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int MAX_SEQ      = (NUM_FRAMES > EXPL_FRAMES) ? NUM_FRAMES : EXPL_FRAMES;
    localparam int FIDX_W       = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
    localparam int HOLD_W       = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int TOTAL_FRAMES = NUM_FRAMES + EXPL_FRAMES;
    localparam int ROM_F_W      = (TOTAL_FRAMES > 1) ? $clog2(TOTAL_FRAMES) : 1;

    localparam logic [FIDX_W-1:0]  FLY_LAST  = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [FIDX_W-1:0]  EXPL_LAST = FIDX_W'(EXPL_FRAMES - 1);
    localparam logic [FIDX_W-1:0]  FIDX_ONE  = FIDX_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [ROM_F_W-1:0] EXPL_BASE = ROM_F_W'(NUM_FRAMES);

    localparam logic [10:0] W_LIM = 11'(OBJECT_WIDTH_X);
    localparam logic [10:0] H_LIM = 11'(OBJECT_HEIGHT_Y);
    localparam logic [10:0] W_MAX = 11'(OBJECT_WIDTH_X - 1);
    localparam logic [10:0] H_MAX = 11'(OBJECT_HEIGHT_Y - 1);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks. Directions 1 and 3 swap rows and
    // columns, which only maps onto the stored bitmap for a square sprite;
    // since direction is a run-time input the sprite must be square.
    // -----------------------------------------------------------------------
    generate
        if (OBJECT_WIDTH_X != OBJECT_HEIGHT_Y) begin : g_chk_square
            $error("sprite_anim_bitmap: rotation needs OBJECT_WIDTH_X == OBJECT_HEIGHT_Y");
        end
        if (FRAME_HOLD < 1) begin : g_chk_hold
            $error("sprite_anim_bitmap: FRAME_HOLD must be at least 1");
        end
        if (NUM_FRAMES < 1 || EXPL_FRAMES < 1) begin : g_chk_frames
            $error("sprite_anim_bitmap: NUM_FRAMES and EXPL_FRAMES must be at least 1");
        end
        if (OBJECT_WIDTH_X < 1 || OBJECT_WIDTH_X > 2047 ||
            OBJECT_HEIGHT_Y < 1 || OBJECT_HEIGHT_Y > 2047) begin : g_chk_size
            $error("sprite_anim_bitmap: sprite dimensions must fit the 11-bit offsets");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Constant ROM image.
    // The bitmap is a fixed closed-form fill indexed by (frame, row, col):
    //   colour = (37*frame + 11*row + 5*col) mod 256
    // Any entry that would collide with the transparent code has its LSB
    // flipped so every in-bracket pixel of a live sprite is drawn.
    // Synthesis folds this into a constant lookup table.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] rom_lookup(
        input logic [ROM_F_W-1:0] f,
        input logic [10:0]        r,
        input logic [10:0]        c
    );
        logic [7:0] v;
        v = 8'(11'(f) * 11'd37 + r * 11'd11 + c * 11'd5);
        if (v == TRANSPARENT_ENCODING) begin
            v = v ^ 8'h01;
        end
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // Animation state machine
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        FLY     = 2'd0,
        EXPLODE = 2'd1,
        GONE    = 2'd2
    } state_t;

    state_t              state;
    logic [FIDX_W-1:0]   frame_idx;
    logic [HOLD_W-1:0]   hold_cnt;

    // Priority: restart > explode > startOfFrame advance.
    // exploding is registered alongside state so it always equals
    // (state == EXPLODE) without a decode after the flops.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= FLY;
            frame_idx     <= '0;
            hold_cnt      <= '0;
            exploding     <= 1'b0;
            explosionDone <= 1'b0;
        end else begin
            explosionDone <= 1'b0;
            if (restart) begin
                state     <= FLY;
                frame_idx <= '0;
                hold_cnt  <= '0;
                exploding <= 1'b0;
            end else if (explode && state == FLY) begin
                state     <= EXPLODE;
                frame_idx <= '0;
                hold_cnt  <= '0;
                exploding <= 1'b1;
            end else if (startOfFrame && state != GONE) begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt <= '0;
                    if (state == FLY) begin
                        frame_idx <= (frame_idx == FLY_LAST) ? '0 : frame_idx + FIDX_ONE;
                    end else if (frame_idx == EXPL_LAST) begin
                        state         <= GONE;
                        frame_idx     <= '0;
                        exploding     <= 1'b0;
                        explosionDone <= 1'b1;
                    end else begin
                        frame_idx <= frame_idx + FIDX_ONE;
                    end
                end else begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pixel path: rotate the offsets into stored (row, col), pick the frame
    // from the state sampled on this same edge, and register the colour.
    // -----------------------------------------------------------------------
    logic              in_range;
    logic [10:0]       rom_row;
    logic [10:0]       rom_col;
    logic [ROM_F_W-1:0] rom_frame;
    logic [7:0]        rom_pixel;

    always_comb begin
        in_range = (offsetX < W_LIM) && (offsetY < H_LIM);

        rom_row = offsetY;
        rom_col = offsetX;
        unique case (direction)
            2'd0: begin
                rom_row = offsetY;
                rom_col = offsetX;
            end
            2'd1: begin
                rom_row = H_MAX - offsetX;
                rom_col = offsetY;
            end
            2'd2: begin
                rom_row = H_MAX - offsetY;
                rom_col = W_MAX - offsetX;
            end
            2'd3: begin
                rom_row = offsetX;
                rom_col = W_MAX - offsetY;
            end
            default: begin
                rom_row = offsetY;
                rom_col = offsetX;
            end
        endcase

        if (state == EXPLODE) begin
            rom_frame = EXPL_BASE + ROM_F_W'(frame_idx);
        end else begin
            rom_frame = ROM_F_W'(frame_idx);
        end

        rom_pixel = rom_lookup(rom_frame, rom_row, rom_col);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBout <= TRANSPARENT_ENCODING;
        end else if (InsideRectangle && in_range && state != GONE) begin
            RGBout <= rom_pixel;
        end else begin
            RGBout <= TRANSPARENT_ENCODING;
        end
    end

    assign drawingRequest = (RGBout != TRANSPARENT_ENCODING);

endmodule

// File: tb/tb_sprite_anim_bitmap.sv
// ---------------------------------------------------------------------------
// tb_sprite_anim_bitmap
//
// Scoreboard bench for sprite_anim_bitmap. A driver applies directed and
// random stimulus on the falling edge and pushes the expected post-edge
// outputs, computed from a phase/pulse-count reference model, into a queue.
// A monitor pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_sprite_anim_bitmap;

    localparam int         W  = 25;
    localparam int         H  = 25;
    localparam int         NF = 4;
    localparam int         EF = 3;
    localparam int         FH = 8;
    localparam logic [7:0] T  = 8'hFF;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] offsetX = '0;
    logic [10:0] offsetY = '0;
    logic        InsideRectangle = 1'b0;
    logic [1:0]  direction = '0;
    logic        startOfFrame = 1'b0;
    logic        explode = 1'b0;
    logic        restart = 1'b0;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic        exploding;
    logic        explosionDone;

    sprite_anim_bitmap #(
        .OBJECT_WIDTH_X      (W),
        .OBJECT_HEIGHT_Y     (H),
        .NUM_FRAMES          (NF),
        .EXPL_FRAMES         (EF),
        .FRAME_HOLD          (FH),
        .TRANSPARENT_ENCODING(T)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .InsideRectangle(InsideRectangle),
        .direction      (direction),
        .startOfFrame   (startOfFrame),
        .explode        (explode),
        .restart        (restart),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .exploding      (exploding),
        .explosionDone  (explosionDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rgb;
        int expl;
        int done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: phase plus number of startOfFrame pulses seen since
    // the phase was entered; the displayed frame follows by division.
    typedef enum {M_FLY, M_EXPL, M_GONE} mphase_t;
    mphase_t m_phase  = M_FLY;
    int      m_pulses = 0;

    function automatic int rom_ref(int f, int r, int c);
        int v;
        v = (f * 37 + r * 11 + c * 5) % 256;
        if (v == 32'(T)) v = v ^ 1;
        return v;
    endfunction

    function automatic int pixel_ref(int ins, int ox, int oy, int dir);
        int frame;
        int row;
        int col;
        if (ins == 0 || ox >= W || oy >= H || m_phase == M_GONE) return 32'(T);
        frame = (m_phase == M_FLY) ? (m_pulses / FH) % NF : NF + m_pulses / FH;
        case (dir)
            0:       begin row = oy;         col = ox;         end
            1:       begin row = H - 1 - ox; col = oy;         end
            2:       begin row = H - 1 - oy; col = W - 1 - ox; end
            default: begin row = ox;         col = W - 1 - oy; end
        endcase
        return rom_ref(frame, row, col);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus. All arguments are 0/1 flags or plain integers.
    task automatic step(int rst_n, int ins, int ox, int oy, int dir,
                        int sof, int expl, int rs);
        exp_t e;
        bit   was_running;
        @(negedge clk);
        was_running     = (resetN == 1'b1);
        resetN          = (rst_n != 0);
        InsideRectangle = (ins != 0);
        offsetX         = 11'(ox);
        offsetY         = 11'(oy);
        direction       = 2'(dir);
        startOfFrame    = (sof != 0);
        explode         = (expl != 0);
        restart         = (rs != 0);

        if (rst_n == 0) begin
            if (was_running) begin
                // reset must act without waiting for a clock edge
                #1;
                check("async_rst_rgb",  32'(RGBout), 32'(T));
                check("async_rst_expl", 32'(exploding), 0);
                check("async_rst_done", 32'(explosionDone), 0);
                check("async_rst_draw", 32'(drawingRequest), 0);
            end
            m_phase  = M_FLY;
            m_pulses = 0;
            e.rgb  = 32'(T);
            e.expl = 0;
            e.done = 0;
        end else begin
            e.rgb  = pixel_ref(ins, ox, oy, dir);
            e.done = 0;
            if (rs != 0) begin
                m_phase  = M_FLY;
                m_pulses = 0;
            end else if (expl != 0 && m_phase == M_FLY) begin
                m_phase  = M_EXPL;
                m_pulses = 0;
            end else if (sof != 0 && m_phase != M_GONE) begin
                m_pulses++;
                if (m_phase == M_EXPL && m_pulses == EF * FH) begin
                    m_phase  = M_GONE;
                    m_pulses = 0;
                    e.done   = 1;
                end else if (m_phase == M_FLY) begin
                    m_pulses = m_pulses % (NF * FH);
                end
            end
            e.expl = (m_phase == M_EXPL) ? 1 : 0;
        end
        sb.push_back(e);
    endtask

    task automatic rand_step(int allow_rst);
        int rst_n;
        int ox;
        int oy;
        rst_n = (allow_rst != 0 && $urandom_range(0, 499) == 0) ? 0 : 1;
        ox = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 27));
        oy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 27));
        step(rst_n,
             ($urandom_range(0, 9) < 8) ? 1 : 0,
             ox, oy,
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0) ? 1 : 0,
             ($urandom_range(0, 39) == 0) ? 1 : 0,
             ($urandom_range(0, 199) == 0) ? 1 : 0);
    endtask

    // Monitor: one expectation per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rgb",       32'(RGBout), e.rgb);
                check("draw_req",  32'(drawingRequest), (e.rgb != 32'(T)) ? 1 : 0);
                check("exploding", 32'(exploding), e.expl);
                check("expl_done", 32'(explosionDone), e.done);
            end
        end
    end

    initial begin
        // held in reset
        repeat (3) step(0, 1, 3, 2, 0, 1, 1, 0);

        // pixel path, direction 0, then outside the bracket
        step(1, 1, 3, 2, 0, 0, 0, 0);
        step(1, 0, 3, 2, 0, 0, 0, 0);
        step(1, 1, 24, 24, 0, 0, 0, 0);
        step(1, 1, 25, 3, 0, 0, 0, 0);
        step(1, 1, 3, 25, 1, 0, 0, 0);

        // flight animation: 32 pulses walk all frames and wrap
        for (int i = 0; i < 34; i++) begin
            step(1, 1, (i * 3) % W, (i * 7) % H, i % 4, 1, 0, 0);
        end

        // explosion plays once, then all pixels transparent
        step(1, 1, 5, 5, 0, 0, 1, 0);
        for (int i = 0; i < EF * FH; i++) begin
            step(1, 1, (i * 5) % W, (i * 11) % H, i % 4, 1, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, i, i, i, 1, 1, 0);
        end

        // collisions
        step(1, 1, 1, 1, 0, 1, 1, 1);
        step(1, 1, 2, 2, 0, 1, 1, 0);
        for (int i = 0; i < FH + 1; i++) begin
            step(1, 1, 4, 6, 1, 1, 0, 0);
        end
        step(1, 1, 7, 7, 3, 1, 0, 1);

        // direction 2 corner and out-of-range column
        step(1, 1, 0, 0, 2, 0, 0, 0);
        step(1, 1, 25, 0, 2, 0, 0, 0);
        step(1, 1, 0, 0, 3, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0, 0);

        // reset during explosion frame 1
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < FH + 2; i++) begin
            step(1, 1, 9, 9, 0, 1, 0, 0);
        end
        step(0, 1, 9, 9, 0, 1, 0, 0);
        step(0, 1, 9, 9, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 9, 9, 0, 1, 0, 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_step(1);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
